data_bridge_cmd_arb: RTL
========================

// Module: data_bridge_cmd_arb
// PURPOSE
//  Merges the write-channel and read-channel DMA command streams of the data bridge onto one shared DMA command port.
//  Arbitration is weighted round-robin, and each channel is held to a per-channel outstanding-command credit limit.
//  A drain handshake stops new grants and reports when the bridge's DMA side is quiescent, so a context update can proceed.
//  Sits between data_bridge (dma_wr_cmd_*/dma_rd_cmd_*) and the host command encoder.
// PARAMETERS
//  TAGW     7   width of the command tag
//  WR_WGT   4   consecutive write grants allowed while read is eligible (>=1)
//  RD_WGT   4   consecutive read grants allowed while write is eligible (>=1)
//  WR_MAX   32  max outstanding write commands (>=1)
//  RD_MAX   32  max outstanding read commands (>=1)
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     asynchronous reset, active low
//  wr_cmd_valid   in   1     write-channel command valid
//  wr_cmd_ready   out  1     write-channel command accepted
//  wr_cmd_data    in   1024  write payload
//  wr_cmd_be      in   128   write byte enables
//  wr_cmd_ea      in   64    write effective address
//  wr_cmd_tag     in   TAGW  write tag
//  rd_cmd_valid   in   1     read-channel command valid
//  rd_cmd_ready   out  1     read-channel command accepted
//  rd_cmd_be      in   128   read byte enables
//  rd_cmd_ea      in   64    read effective address
//  rd_cmd_tag     in   TAGW  read tag
//  m_cmd_valid    out  1     merged command valid
//  m_cmd_ready    in   1     downstream accepts merged command
//  m_cmd_is_rd    out  1     1 = read command, 0 = write command
//  m_cmd_data     out  1024  payload; 0 for reads
//  m_cmd_be       out  128   byte enables
//  m_cmd_ea       out  64    effective address
//  m_cmd_tag      out  TAGW  tag
//  wr_resp_valid  in   1     one write response completed (returns one credit)
//  rd_resp_valid  in   1     one read command fully completed (returns one credit)
//  drain_req      in   1     level; block new grants (context update)
//  drain_done     out  1     drained: drain_req & no outstanding & m_cmd_valid=0
//  credit_err     out  1     sticky: a response arrived while that counter was 0
// BEHAVIOUR
//  Reset: all outputs 0, both outstanding counters 0, burst counter 0, last_gnt=RD (write has first preference).
//  Reset mid-operation: the merged output is dropped and credits are lost. Upstream must reset together with this block.
//  Output stage: one register. load_en = !m_cmd_valid | m_cmd_ready.
//    Latency is 1 cycle from input accept to m_cmd_valid.
//    Full throughput: one command per cycle.
//    Output fields hold stable while valid & !ready.
//  Eligibility:
//    elig_wr = wr_cmd_valid & wr_out<WR_MAX & !drain_req
//    elig_rd = rd_cmd_valid & rd_out<RD_MAX & !drain_req
//  Grant (combinational, only when load_en):
//    Only one channel eligible -> grant it.
//    Both eligible -> grant last_gnt while burst<WGT(last_gnt)-1; otherwise grant the other channel.
//  Ready: xx_cmd_ready = load_en & gnt_xx. Never both high. Ready may depend on valid; upstream must not depend on ready.
//  On grant:
//    Output register <= selected fields.
//    burst <= (gnt==last_gnt) ? burst+1 : 0, saturating at max weight.
//    last_gnt <= gnt.
//  Credits:
//    xx_out increments on grant and decrements on xx_resp_valid.
//    Simultaneous increment and decrement leaves the counter unchanged.
//    A decrement at 0 leaves the counter at 0 and sets credit_err (cleared only by reset).
//  Counter width: $clog2(MAX+1). The counter never exceeds MAX, because eligibility blocks grants at MAX.
//  Drain:
//    drain_req gates eligibility the same cycle it rises. A command already in the output register still drains.
//    drain_done is registered: it asserts the cycle after the condition is met and drops the cycle after drain_req falls.
//    Deasserting drain_req resumes arbitration, and burst state is preserved.
//  No combinational path from m_cmd_ready to m_cmd_* fields. The m_cmd_ready -> xx_cmd_ready path is allowed.
// STRUCTURE
//  Shared package (data_bridge_pkg): GNT_WR=1'b0 / GNT_RD=1'b1 encodings and the default weight and credit constants.
//  One sub-module: data_bridge_credit_cnt (parameterised MAX: inc, dec, cnt, avail, err). Instantiated twice.
//  Arbiter and output register live inline; no FSM beyond last_gnt and the burst counter.
// TESTING
//  Write-only stream, 8 cmds, m_cmd_ready=1 -> 8 consecutive outputs with is_rd=0; wr_out ends at 8.
//  Both valid continuously, WGT=4/4, no backpressure -> grant pattern W,W,W,W,R,R,R,R,W...
//  WR_MAX=2, no responses -> 2 writes issued, then wr_cmd_ready=0 while reads continue.
//    One wr_resp_valid -> exactly one more write is issued.
//  m_cmd_ready=0 for 5 cycles with a command held -> fields stable, both input readys 0.
//    Release -> exactly one handoff with no duplicate.
//  drain_req with 3 reads outstanding -> no new grants.
//    drain_done=1 one cycle after the 3rd rd_resp_valid and m_cmd_valid=0.
//  rd_resp_valid with rd_out=0 -> credit_err=1 and stays 1; counter stays 0.

Source files
------------

// File: rtl/data_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_bridge_pkg                                                  |
// | Brief   : Shared grant encodings and default sizing for the data bridge.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package data_bridge_pkg;

    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

    localparam int c_def_tagw = 7;
    localparam int c_def_wgt  = 4;
    localparam int c_def_max  = 32;

endpackage
`default_nettype wire

// File: rtl/data_bridge_credit_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_bridge_credit_cnt                                           |
// | Brief   : Outstanding-command credit counter with sticky underflow flag.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module data_bridge_credit_cnt
    import data_bridge_pkg::*;
#(
    parameter int MAX = c_def_max
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inc,
    input  logic                       dec,
    output logic [$clog2(MAX+1)-1:0]   cnt,
    output logic                       avail,
    output logic                       err
);

    localparam int              c_w   = $clog2(MAX + 1);
    localparam logic [c_w-1:0]  c_max = c_w'(MAX);

    logic [c_w-1:0] r_cnt;
    logic           r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (r_cnt != c_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (dec && !inc) begin
                // A response with nothing outstanding is a protocol error upstream.
                if (r_cnt == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign cnt   = r_cnt;
    assign avail = (r_cnt < c_max);
    assign err   = r_err;

endmodule
`default_nettype wire

// File: rtl/data_bridge_cmd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_bridge_cmd_arb                                              |
// | Brief   : Weighted round-robin merge of write/read DMA commands with       |
// |           per-channel credit limits and a drain handshake.                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module data_bridge_cmd_arb
    import data_bridge_pkg::*;
#(
    parameter int TAGW   = c_def_tagw,
    parameter int WR_WGT = c_def_wgt,
    parameter int RD_WGT = c_def_wgt,
    parameter int WR_MAX = c_def_max,
    parameter int RD_MAX = c_def_max
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_cmd_valid,
    output logic             wr_cmd_ready,
    input  logic [1023:0]    wr_cmd_data,
    input  logic [127:0]     wr_cmd_be,
    input  logic [63:0]      wr_cmd_ea,
    input  logic [TAGW-1:0]  wr_cmd_tag,
    input  logic             rd_cmd_valid,
    output logic             rd_cmd_ready,
    input  logic [127:0]     rd_cmd_be,
    input  logic [63:0]      rd_cmd_ea,
    input  logic [TAGW-1:0]  rd_cmd_tag,
    output logic             m_cmd_valid,
    input  logic             m_cmd_ready,
    output logic             m_cmd_is_rd,
    output logic [1023:0]    m_cmd_data,
    output logic [127:0]     m_cmd_be,
    output logic [63:0]      m_cmd_ea,
    output logic [TAGW-1:0]  m_cmd_tag,
    input  logic             wr_resp_valid,
    input  logic             rd_resp_valid,
    input  logic             drain_req,
    output logic             drain_done,
    output logic             credit_err
);

    localparam int               c_max_wgt   = (WR_WGT > RD_WGT) ? WR_WGT : RD_WGT;
    localparam int               c_bw        = $clog2(c_max_wgt + 1);
    localparam logic [c_bw-1:0]  c_wr_lim    = c_bw'(WR_WGT - 1);
    localparam logic [c_bw-1:0]  c_rd_lim    = c_bw'(RD_WGT - 1);
    localparam logic [c_bw-1:0]  c_burst_sat = c_bw'(c_max_wgt);

    logic                          r_m_valid;
    logic                          r_m_is_rd;
    logic [1023:0]                 r_m_data;
    logic [127:0]                  r_m_be;
    logic [63:0]                   r_m_ea;
    logic [TAGW-1:0]               r_m_tag;
    logic                          r_last_gnt;
    logic [c_bw-1:0]               r_burst;
    logic                          r_primed;
    logic                          r_drain_done;

    logic                          w_load_en;
    logic                          w_elig_wr;
    logic                          w_elig_rd;
    logic                          w_gnt_any;
    logic                          w_gnt_sel;
    logic                          w_gnt_wr;
    logic                          w_gnt_rd;
    logic [c_bw-1:0]               w_last_lim;
    logic                          w_wr_avail;
    logic                          w_rd_avail;
    logic                          w_wr_err;
    logic                          w_rd_err;
    logic [$clog2(WR_MAX+1)-1:0]   w_wr_cnt;
    logic [$clog2(RD_MAX+1)-1:0]   w_rd_cnt;

    data_bridge_credit_cnt #(.MAX(WR_MAX)) u_wr_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_gnt_wr),
        .dec   (wr_resp_valid),
        .cnt   (w_wr_cnt),
        .avail (w_wr_avail),
        .err   (w_wr_err)
    );

    data_bridge_credit_cnt #(.MAX(RD_MAX)) u_rd_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_gnt_rd),
        .dec   (rd_resp_valid),
        .cnt   (w_rd_cnt),
        .avail (w_rd_avail),
        .err   (w_rd_err)
    );

    assign w_load_en  = !r_m_valid || m_cmd_ready;
    assign w_elig_wr  = wr_cmd_valid && w_wr_avail && !drain_req;
    assign w_elig_rd  = rd_cmd_valid && w_rd_avail && !drain_req;
    assign w_last_lim = (r_last_gnt == GNT_RD) ? c_rd_lim : c_wr_lim;

    // Until the first grant the read burst counts as spent, so write goes first.
    always_comb begin
        w_gnt_any = w_load_en && (w_elig_wr || w_elig_rd);
        w_gnt_sel = GNT_WR;
        if (w_elig_wr && w_elig_rd) begin
            if (!r_primed) begin
                w_gnt_sel = GNT_WR;
            end else if (r_burst < w_last_lim) begin
                w_gnt_sel = r_last_gnt;
            end else begin
                w_gnt_sel = ~r_last_gnt;
            end
        end else if (w_elig_rd) begin
            w_gnt_sel = GNT_RD;
        end
    end

    assign w_gnt_wr = w_gnt_any && (w_gnt_sel == GNT_WR);
    assign w_gnt_rd = w_gnt_any && (w_gnt_sel == GNT_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid    <= 1'b0;
            r_m_is_rd    <= 1'b0;
            r_m_data     <= '0;
            r_m_be       <= '0;
            r_m_ea       <= '0;
            r_m_tag      <= '0;
            r_last_gnt   <= GNT_RD;
            r_burst      <= '0;
            r_primed     <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            if (w_load_en) begin
                r_m_valid <= w_gnt_any;
            end
            if (w_gnt_any) begin
                r_m_is_rd <= w_gnt_sel;
                if (w_gnt_sel == GNT_RD) begin
                    r_m_data <= '0;
                    r_m_be   <= rd_cmd_be;
                    r_m_ea   <= rd_cmd_ea;
                    r_m_tag  <= rd_cmd_tag;
                end else begin
                    r_m_data <= wr_cmd_data;
                    r_m_be   <= wr_cmd_be;
                    r_m_ea   <= wr_cmd_ea;
                    r_m_tag  <= wr_cmd_tag;
                end
                if (r_primed && (w_gnt_sel == r_last_gnt)) begin
                    if (r_burst != c_burst_sat) begin
                        r_burst <= r_burst + 1'b1;
                    end
                end else begin
                    r_burst <= '0;
                end
                r_last_gnt <= w_gnt_sel;
                r_primed   <= 1'b1;
            end
            r_drain_done <= drain_req && (w_wr_cnt == '0) && (w_rd_cnt == '0) && !r_m_valid;
        end
    end

    assign wr_cmd_ready = w_gnt_wr;
    assign rd_cmd_ready = w_gnt_rd;
    assign m_cmd_valid  = r_m_valid;
    assign m_cmd_is_rd  = r_m_is_rd;
    assign m_cmd_data   = r_m_data;
    assign m_cmd_be     = r_m_be;
    assign m_cmd_ea     = r_m_ea;
    assign m_cmd_tag    = r_m_tag;
    assign drain_done   = r_drain_done;
    assign credit_err   = w_wr_err || w_rd_err;

endmodule
`default_nettype wire
